// File: rtl/qmac_pkg.sv
// Shared constants, width helpers and the pipeline stage record for the
// sign-magnitude Q-format MAC.
package qmac_pkg;

  localparam int QMAC_LAT   = 3;
  localparam int QMAC_N_MAX = 64;
  localparam int QMAC_MAG_W = 2 * QMAC_N_MAX - 2;

  function automatic int qmac_prod_w(input int n);
    return 2 * n - 2;
  endfunction

  function automatic int qmac_sum_w(input int n);
    return 2 * n;
  endfunction

  // S1 packs both operand magnitudes into the magnitude field; S2 holds the product there.
  typedef struct packed {
    logic                  valid;
    logic                  sign;
    logic [QMAC_MAG_W-1:0] magnitude;
    logic                  acc;
    logic                  round;
  } qmac_stage_t;

endpackage

// File: rtl/qmac_if.sv
// Handshake and data bundle of the MAC element; the block sits on the slave side.
interface qmac_if #(
  parameter int N = 32
) ();

  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_multiplicand;
  logic [N-1:0] i_multiplier;
  logic         i_acc;
  logic         i_round;
  logic         i_ovr_clr;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] o_result;
  logic         o_ovr;
  logic         o_ovr_sticky;

  modport master (
    output i_valid, i_multiplicand, i_multiplier, i_acc, i_round, i_ovr_clr, i_ready,
    input  o_ready, o_valid, o_result, o_ovr, o_ovr_sticky
  );

  modport slave (
    input  i_valid, i_multiplicand, i_multiplier, i_acc, i_round, i_ovr_clr, i_ready,
    output o_ready, o_valid, o_result, o_ovr, o_ovr_sticky
  );

endinterface

// File: rtl/qmac_sat.sv
// Clamps a two's-complement sum to the N-bit symmetric range and returns it in
// both sign-magnitude (for the output) and two's-complement (for the accumulator).
module qmac_sat
  import qmac_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [qmac_sum_w(N)-1:0] i_sum,
  output logic [N-1:0]             o_result,
  output logic [N-1:0]             o_acc,
  output logic                     o_ovr
);

  localparam int SW = qmac_sum_w(N);

  logic          neg_s;
  logic [SW-1:0] abs_s;
  logic [SW-1:0] max_s;
  logic [N-2:0]  mag_s;

  // Magnitude, clamp and both output encodings
  always_comb begin
    neg_s = i_sum[SW-1];
    max_s = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    if (neg_s) begin
      abs_s = -i_sum;
    end else begin
      abs_s = i_sum;
    end
    if (abs_s > max_s) begin
      o_ovr = 1'b1;
      mag_s = {(N-1){1'b1}};
    end else begin
      o_ovr = 1'b0;
      mag_s = abs_s[N-2:0];
    end
    o_result = {neg_s & (|mag_s), mag_s};
    if (neg_s) begin
      o_acc = -{1'b0, mag_s};
    end else begin
      o_acc = {1'b0, mag_s};
    end
  end

endmodule

// File: rtl/qmac_pipe.sv
// Three-stage sign-magnitude Q-format multiply / accumulate with saturation and a
// single global advance shared by every stage.
module qmac_pipe
  import qmac_pkg::*;
#(
  parameter int N = 32,
  parameter int Q = 15
) (
  input logic   i_clk,
  input logic   i_rst_n,
  qmac_if.slave bus
);

  localparam int PW = qmac_prod_w(N);
  localparam int SW = qmac_sum_w(N);
  localparam int RW = PW + 1;

  qmac_stage_t  s1_d, s1_q, s2_d, s2_q;
  logic         adv_s;
  logic [N-2:0] a_mag_s, b_mag_s;
  logic [PW-1:0] prod_s;
  logic [RW-1:0] rnd_add_s, scaled_s;
  logic [SW-1:0] prod_tc_s, acc_ext_s, sum_s;
  logic [N-1:0] sat_result_s, sat_acc_s;
  logic         sat_ovr_s;
  logic [N-1:0] result_d, result_q, acc_d, acc_q;
  logic         valid_d, valid_q, ovr_d, ovr_q, sticky_d, sticky_q;
  logic         unused_mag_s;

  assign adv_s            = !valid_q || bus.i_ready;
  assign bus.o_ready      = adv_s;
  assign bus.o_valid      = valid_q;
  assign bus.o_result     = result_q;
  assign bus.o_ovr        = ovr_q;
  assign bus.o_ovr_sticky = sticky_q;
  // Spare magnitude bits above the product width when N < QMAC_N_MAX.
  assign unused_mag_s     = ^{s1_q.magnitude, s2_q.magnitude};

  // S1: capture operand magnitudes, product sign and per-beat controls
  always_comb begin
    s1_d = s1_q;
    if (adv_s) begin
      s1_d.valid     = bus.i_valid;
      s1_d.sign      = bus.i_multiplicand[N-1] ^ bus.i_multiplier[N-1];
      s1_d.magnitude = '0;
      s1_d.magnitude[PW-1:0] = {bus.i_multiplier[N-2:0], bus.i_multiplicand[N-2:0]};
      s1_d.acc       = bus.i_acc;
      s1_d.round     = bus.i_round;
    end else begin
      s1_d = s1_q;
    end
  end

  // S2: unsigned magnitude product
  always_comb begin
    a_mag_s = s1_q.magnitude[N-2:0];
    b_mag_s = s1_q.magnitude[PW-1:N-1];
    prod_s  = {{(N-1){1'b0}}, a_mag_s} * {{(N-1){1'b0}}, b_mag_s};
    s2_d    = s2_q;
    if (adv_s) begin
      s2_d = s1_q;
      s2_d.magnitude = '0;
      s2_d.magnitude[PW-1:0] = prod_s;
    end else begin
      s2_d = s2_q;
    end
  end

  // S3 datapath: scale with optional half-up rounding, apply sign, accumulate
  always_comb begin
    if (s2_q.round) begin
      rnd_add_s = {{(RW-1){1'b0}}, 1'b1} << (Q - 1);
    end else begin
      rnd_add_s = '0;
    end
    scaled_s  = ({1'b0, s2_q.magnitude[PW-1:0]} + rnd_add_s) >> Q;
    // Negating a zero magnitude yields zero, so no negative zero reaches the sum.
    if (s2_q.sign) begin
      prod_tc_s = -{1'b0, scaled_s};
    end else begin
      prod_tc_s = {1'b0, scaled_s};
    end
    acc_ext_s = {{N{acc_q[N-1]}}, acc_q};
    if (s2_q.acc) begin
      sum_s = acc_ext_s + prod_tc_s;
    end else begin
      sum_s = prod_tc_s;
    end
  end

  qmac_sat #(.N(N)) u_sat (
    .i_sum    (sum_s),
    .o_result (sat_result_s),
    .o_acc    (sat_acc_s),
    .o_ovr    (sat_ovr_s)
  );

  // Output register, accumulator and sticky flag next-state
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    ovr_d    = ovr_q;
    acc_d    = acc_q;
    if (adv_s) begin
      valid_d = s2_q.valid;
      if (s2_q.valid) begin
        result_d = sat_result_s;
        ovr_d    = sat_ovr_s;
        acc_d    = sat_acc_s;
      end else begin
        result_d = result_q;
        ovr_d    = ovr_q;
        acc_d    = acc_q;
      end
    end else begin
      valid_d = valid_q;
    end
    if (adv_s && s2_q.valid && sat_ovr_s) begin
      sticky_d = 1'b1;
    end else if (bus.i_ovr_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // State registers for all three stages
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      ovr_q    <= 1'b0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      ovr_q    <= ovr_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
    end
  end

endmodule
